// File: rtl/instr_bus_router.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | instr_bus_router: routes Ibex instruction fetches to NUM_SLAVES memories,   |
// | keeps responses in order and answers unmapped fetches with an error.        |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module instr_bus_router #(
    parameter int unsigned NUM_SLAVES      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    // Default windows: boot ROM (slave 0) and code RAM (slave 1)
    parameter logic [31:0] SLAVE_BASE_ADDRESSES [NUM_SLAVES] = '{32'h0000_0000, 32'h0010_0000},
    parameter logic [31:0] SLAVE_END_ADDRESSES  [NUM_SLAVES] = '{32'h0000_0FFF, 32'h0010_FFFF}
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   core_req,
    input  logic [31:0]                            core_addr,
    output logic                                   core_gnt,
    output logic                                   core_rvalid,
    output logic [31:0]                            core_rdata,
    output logic [6:0]                             core_rdata_intg,
    output logic                                   core_err,
    output logic [NUM_SLAVES-1:0]                  slave_req,
    output logic [NUM_SLAVES*32-1:0]               slave_addr,
    input  logic [NUM_SLAVES-1:0]                  slave_gnt,
    input  logic [NUM_SLAVES-1:0]                  slave_rvalid,
    input  logic [NUM_SLAVES*32-1:0]               slave_rdata,
    input  logic [NUM_SLAVES*7-1:0]                slave_rdata_intg,
    input  logic [NUM_SLAVES-1:0]                  slave_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    localparam int unsigned TGT_W = $clog2(NUM_SLAVES + 1);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [TGT_W-1:0] TGT_ERR = TGT_W'(NUM_SLAVES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [TGT_W-1:0]      fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TGT_W-1:0]      last_tgt_q, last_tgt_d;

    logic [TGT_W-1:0]      tgt;
    logic [TGT_W-1:0]      head_tgt;
    logic [NUM_SLAVES-1:0] head_oh;
    logic [CNT_W-1:0]      count_after_pop;
    logic                  pop;
    logic                  push;
    logic                  issuable;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Descending scan so the lowest matching window wins
    always_comb begin
        tgt = TGT_ERR;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((core_addr >= SLAVE_BASE_ADDRESSES[i]) && (core_addr <= SLAVE_END_ADDRESSES[i])) begin
                tgt = TGT_W'(i);
            end
        end
    end

    assign head_tgt = fifo_q[rd_ptr_q];

    always_comb begin
        core_rvalid     = 1'b0;
        core_rdata      = '0;
        core_rdata_intg = '0;
        core_err        = 1'b0;
        pop             = 1'b0;
        head_oh         = '0;
        if (count_q != '0) begin
            if (head_tgt == TGT_ERR) begin
                core_rvalid = 1'b1;
                core_err    = 1'b1;
                pop         = 1'b1;
            end else begin
                for (int i = 0; i < int'(NUM_SLAVES); i++) begin
                    if (head_tgt == TGT_W'(i)) begin
                        head_oh[i]      = 1'b1;
                        core_rvalid     = slave_rvalid[i];
                        core_rdata      = slave_rdata[i*32 +: 32];
                        core_rdata_intg = slave_rdata_intg[i*7 +: 7];
                        core_err        = slave_err[i];
                        pop             = slave_rvalid[i];
                    end
                end
            end
        end
    end

    // Occupancy as seen after this cycle's pop, so a draining entry frees its slot immediately
    assign count_after_pop = count_q - CNT_W'(pop);
    assign issuable = (count_after_pop < CNT_MAX) &&
                      ((count_after_pop == '0) || (tgt == last_tgt_q));

    always_comb begin
        slave_req  = '0;
        slave_addr = '0;
        core_gnt   = 1'b0;
        if (core_req && issuable) begin
            if (tgt == TGT_ERR) begin
                core_gnt = 1'b1;
            end else begin
                for (int i = 0; i < int'(NUM_SLAVES); i++) begin
                    if (tgt == TGT_W'(i)) begin
                        slave_req[i]           = 1'b1;
                        slave_addr[i*32 +: 32] = core_addr;
                        core_gnt               = slave_gnt[i];
                    end
                end
            end
        end
    end

    assign push = core_req & core_gnt;

    always_comb begin
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        last_tgt_d = push ? tgt : last_tgt_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            last_tgt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            last_tgt_q <= last_tgt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= tgt;
        end
    end

    assign outstanding = count_q;

    // A response from any slave other than the queue head is a protocol violation
    assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == '0) || ((slave_rvalid & ~head_oh) == '0));

endmodule
`default_nettype wire
